// File: rtl/periph_cmd_master.sv
// periph_cmd_master: Avalon-MM host turning a valid/ready command stream into
// single-beat reads/writes on the pb_cpu_0_s0 agent, with in-order read responses
// and timeout recovery for a hung agent.
// Ports:
//   clk_clk / reset_reset        clock, synchronous active-high reset
//   cmd_*                        command stream in (valid/ready handshake)
//   rsp_*                        read response stream out (first-word-fall-through)
//   m0_*                         Avalon-MM host port
//   err_clear / err_sticky       sticky timeout flag and its clear
//   busy                         request active, reads in flight or late beats pending
module periph_cmd_master #(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MAX_PENDING = 4,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_address,
    input  logic [DATA_W-1:0]   cmd_writedata,
    input  logic [DATA_W/8-1:0] cmd_byteenable,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_readdata,
    output logic                rsp_error,
    output logic [ADDR_W-1:0]   m0_address,
    output logic                m0_read,
    output logic                m0_write,
    output logic [DATA_W-1:0]   m0_writedata,
    output logic [DATA_W/8-1:0] m0_byteenable,
    output logic                m0_burstcount,
    output logic                m0_debugaccess,
    input  logic                m0_waitrequest,
    input  logic [DATA_W-1:0]   m0_readdata,
    input  logic                m0_readdatavalid,
    input  logic                err_clear,
    output logic                err_sticky,
    output logic                busy
);

    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned PTR_W  = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
    localparam int unsigned CNT_W  = $clog2(MAX_PENDING + 1);
    localparam int unsigned CRED_W = CNT_W + 1;
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_ABORT, ST_FLUSH} state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              err;
    } rsp_t;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                rd_q, rd_d, wr_q, wr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [CNT_W-1:0]    inflight_q, inflight_d;
    logic [CNT_W-1:0]    drop_q, drop_d;
    logic [CNT_W-1:0]    flush_q, flush_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                err_q, err_d;
    logic                busy_q;

    rsp_t                mem_q [MAX_PENDING];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    fcnt_q;

    logic                push_c, pop_c, cmd_ready_c;
    rsp_t                push_rsp_c;
    logic [CRED_W-1:0]   cred_c;
    logic                xfer_done_c, tmo_run_c, progress_c, tmo_hit_c, credit_ok_c;

    // Next-state, Avalon request, credit and timeout logic
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        inflight_d  = inflight_q;
        drop_d      = drop_q;
        flush_d     = flush_q;
        tmo_d       = tmo_q;
        err_d       = err_q & ~err_clear;
        push_c      = 1'b0;
        push_rsp_c  = '0;
        cmd_ready_c = 1'b0;

        // A read still being presented will occupy a credit once it completes
        cred_c      = CRED_W'(inflight_q) + CRED_W'(fcnt_q)
                    + CRED_W'((state_q == ST_REQ) && rd_q);
        xfer_done_c = (state_q == ST_REQ) && !m0_waitrequest;
        tmo_run_c   = ((state_q == ST_IDLE) || (state_q == ST_REQ))
                    && (((state_q == ST_REQ) && m0_waitrequest)
                        || (inflight_q != '0) || (drop_q != '0));
        progress_c  = xfer_done_c || m0_readdatavalid;
        tmo_hit_c   = tmo_run_c && !progress_c && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
        credit_ok_c = (cred_c < CRED_W'(MAX_PENDING)) && (drop_q == '0) && !tmo_hit_c;

        if (!tmo_run_c || progress_c || tmo_hit_c) tmo_d = '0;
        else                                        tmo_d = tmo_q + TMO_W'(1);

        if (xfer_done_c && rd_q) inflight_d = inflight_d + CNT_W'(1);

        // Beats owed to an aborted batch are swallowed; others go to the response FIFO
        if (m0_readdatavalid) begin
            if (drop_q != '0) begin
                drop_d = drop_q - CNT_W'(1);
            end else if (((state_q == ST_IDLE) || (state_q == ST_REQ)) && (inflight_q != '0)) begin
                push_c          = 1'b1;
                push_rsp_c.data = m0_readdata;
                push_rsp_c.err  = 1'b0;
                inflight_d      = inflight_d - CNT_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: cmd_ready_c = credit_ok_c;
            ST_REQ: begin
                if (!m0_waitrequest) begin
                    cmd_ready_c = credit_ok_c;
                    if (!(cmd_valid && credit_ok_c)) begin
                        state_d = ST_IDLE;
                        rd_d    = 1'b0;
                        wr_d    = 1'b0;
                    end
                end
            end
            ST_ABORT: state_d = (flush_q != '0) ? ST_FLUSH : ST_IDLE;
            ST_FLUSH: begin
                push_c          = 1'b1;
                push_rsp_c.data = '0;
                push_rsp_c.err  = 1'b1;
                flush_d         = flush_q - CNT_W'(1);
                if (flush_q == CNT_W'(1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (cmd_valid && cmd_ready_c) begin
            state_d = ST_REQ;
            addr_d  = cmd_address;
            wdata_d = cmd_writedata;
            be_d    = cmd_byteenable;
            rd_d    = !cmd_write;
            wr_d    = cmd_write;
        end

        // Timeout: either give up on late beats, or abort and flush error responses.
        // The abandoned request was never accepted by the agent, so only the
        // in-flight reads can still produce late beats.
        if (tmo_hit_c) begin
            if (drop_q != '0) begin
                drop_d = '0;
            end else begin
                flush_d    = inflight_q + CNT_W'((state_q == ST_REQ) && rd_q);
                drop_d     = inflight_q;
                inflight_d = '0;
                rd_d       = 1'b0;
                wr_d       = 1'b0;
                err_d      = 1'b1;
                state_d    = ST_ABORT;
            end
        end
    end

    assign pop_c = rsp_ready && (fcnt_q != '0);

    // State and request registers
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            be_q       <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            flush_q    <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            flush_q    <= flush_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            busy_q     <= (state_d != ST_IDLE) || (inflight_d != '0) || (drop_d != '0);
        end
    end

    // Response FIFO, first-word-fall-through
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
            for (int i = 0; i < int'(MAX_PENDING); i++) mem_q[i] <= '0;
        end else begin
            if (push_c) begin
                mem_q[wr_ptr_q] <= push_rsp_c;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            fcnt_q <= fcnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    assign cmd_ready      = cmd_ready_c && !reset_reset;
    assign rsp_valid      = (fcnt_q != '0);
    assign rsp_readdata   = mem_q[rd_ptr_q].data;
    assign rsp_error      = mem_q[rd_ptr_q].err;
    assign m0_address     = addr_q;
    assign m0_read        = rd_q;
    assign m0_write       = wr_q;
    assign m0_writedata   = wdata_q;
    assign m0_byteenable  = be_q;
    assign m0_burstcount  = 1'b1;
    assign m0_debugaccess = 1'b0;
    assign err_sticky     = err_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_periph_cmd_master.sv
// Directed bench for periph_cmd_master: writes, stalled reads, credit limit,
// same-cycle issue/return, timeout aborts with late beats, and reset mid-request.
module tb_periph_cmd_master;

    logic        clk_clk = 1'b0;
    logic        reset_reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [8:0]  cmd_address;
    logic [31:0] cmd_writedata;
    logic [3:0]  cmd_byteenable;
    logic        rsp_valid, rsp_ready, rsp_error;
    logic [31:0] rsp_readdata;
    logic [8:0]  m0_address;
    logic        m0_read, m0_write;
    logic [31:0] m0_writedata;
    logic [3:0]  m0_byteenable;
    logic        m0_burstcount, m0_debugaccess;
    logic        m0_waitrequest;
    logic [31:0] m0_readdata;
    logic        m0_readdatavalid;
    logic        err_clear, err_sticky, busy;

    int total = 0;
    int bad   = 0;

    periph_cmd_master dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_address(cmd_address), .cmd_writedata(cmd_writedata), .cmd_byteenable(cmd_byteenable),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_readdata(rsp_readdata), .rsp_error(rsp_error),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_burstcount(m0_burstcount), .m0_debugaccess(m0_debugaccess),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .err_clear(err_clear), .err_sticky(err_sticky), .busy(busy)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] data, input logic err);
        chk({tag, "_valid"}, rsp_valid, 1'b1);
        chk({tag, "_data"}, rsp_readdata, data);
        chk({tag, "_err"}, rsp_error, err);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        int n;
        int acc;
        reset_reset = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = '0;
        cmd_writedata = '0; cmd_byteenable = '0; rsp_ready = 1'b0;
        m0_waitrequest = 1'b0; m0_readdata = '0; m0_readdatavalid = 1'b0; err_clear = 1'b0;
        tick(); tick();
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        cmd_valid = 1'b0;
        tick();
        reset_reset = 1'b0;
        tick();
        chk("rst_m0_read", m0_read, 1'b0);
        chk("rst_m0_write", m0_write, 1'b0);
        chk("rst_m0_addr", m0_address, 9'h0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_err", err_sticky, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("const_burst", m0_burstcount, 1'b1);
        chk("const_dbg", m0_debugaccess, 1'b0);

        // Single write, no wait states
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 9'h10;
        cmd_writedata = 32'h5; cmd_byteenable = 4'hF;
        #1 chk("wr_ready", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
        chk("wr_m0_write", m0_write, 1'b1);
        chk("wr_m0_read", m0_read, 1'b0);
        chk("wr_addr", m0_address, 9'h10);
        chk("wr_data", m0_writedata, 32'h5);
        chk("wr_be", m0_byteenable, 4'hF);
        chk("wr_busy", busy, 1'b1);
        tick();
        chk("wr_drop", m0_write, 1'b0);
        chk("wr_no_rsp", rsp_valid, 1'b0);
        chk("wr_idle", busy, 1'b0);

        // Read held through 3 wait-state cycles, data two cycles after completion
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 9'h20; m0_waitrequest = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rd_held", m0_read, 1'b1);
            chk("rd_addr", m0_address, 9'h20);
            if (i == 3) m0_waitrequest = 1'b0;
            tick();
        end
        chk("rd_done", m0_read, 1'b0);
        chk("rd_busy_inflight", busy, 1'b1);
        tick();
        m0_readdatavalid = 1'b1; m0_readdata = 32'hA5;
        tick();
        m0_readdatavalid = 1'b0;
        chk("rd_busy_clear", busy, 1'b0);
        pop_chk("rd_rsp", 32'hA5, 1'b0);
        chk("rd_empty", rsp_valid, 1'b0);

        // Five back-to-back reads against four credits, responses not consumed
        cmd_valid = 1'b1; cmd_address = 9'h00; acc = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (cmd_ready) acc++;
            tick();
            cmd_address = 9'(acc * 4);
        end
        chk("cred_accepted", acc, 4);
        chk("cred_ready0", cmd_ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
            m0_readdatavalid = 1'b1; m0_readdata = 32'h100 + i;
            tick();
        end
        m0_readdatavalid = 1'b0;
        #1 chk("cred_full_fifo", cmd_ready, 1'b0);
        pop_chk("cred_pop0", 32'h100, 1'b0);
        chk("cred_ready_after_pop", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
        chk("fifth_issue", m0_read, 1'b1);
        chk("fifth_addr", m0_address, 9'h10);
        tick();
        pop_chk("cred_pop1", 32'h101, 1'b0);
        pop_chk("cred_pop2", 32'h102, 1'b0);
        pop_chk("cred_pop3", 32'h103, 1'b0);

        // Read issue completing in the same cycle as an earlier read's data
        cmd_valid = 1'b1; cmd_address = 9'h14;
        tick();
        cmd_valid = 1'b0;
        m0_readdatavalid = 1'b1; m0_readdata = 32'h210;
        tick();
        m0_readdatavalid = 1'b0;
        chk("same_busy", busy, 1'b1);
        m0_readdatavalid = 1'b1; m0_readdata = 32'h214;
        tick();
        m0_readdatavalid = 1'b0;
        chk("same_busy_done", busy, 1'b0);
        pop_chk("same_rsp0", 32'h210, 1'b0);
        pop_chk("same_rsp1", 32'h214, 1'b0);
        chk("same_empty", rsp_valid, 1'b0);

        // Read stuck behind waitrequest until timeout
        cmd_valid = 1'b1; cmd_address = 9'h30; m0_waitrequest = 1'b1;
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 1100) begin
            if (n == 1000) chk("tmo_not_early", m0_read, 1'b1);
            tick();
            n++;
        end
        chk("tmo_seen", n < 1100, 1'b1);
        chk("tmo_lat_lo", n >= 1024, 1'b1);
        chk("tmo_lat_hi", n <= 1030, 1'b1);
        m0_waitrequest = 1'b0;
        chk("tmo_m0_read", m0_read, 1'b0);
        chk("tmo_sticky", err_sticky, 1'b1);
        pop_chk("tmo_rsp", 32'h0, 1'b1);
        chk("tmo_empty", rsp_valid, 1'b0);
        chk("tmo_busy", busy, 1'b0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("err_cleared", err_sticky, 1'b0);

        // Two reads in flight with no data: two error responses, late beats dropped
        cmd_valid = 1'b1; cmd_address = 9'h40;
        tick();
        cmd_address = 9'h44;
        tick();
        cmd_valid = 1'b0;
        tick();
        n = 0;
        while (!rsp_valid && n < 1100) begin
            tick();
            n++;
        end
        chk("tmo2_seen", n < 1100, 1'b1);
        tick();
        pop_chk("tmo2_rsp0", 32'h0, 1'b1);
        pop_chk("tmo2_rsp1", 32'h0, 1'b1);
        chk("tmo2_empty", rsp_valid, 1'b0);
        chk("tmo2_sticky", err_sticky, 1'b1);
        chk("tmo2_busy_drop", busy, 1'b1);
        cmd_valid = 1'b1; cmd_address = 9'h48;
        #1 chk("tmo2_blocked", cmd_ready, 1'b0);
        cmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m0_readdatavalid = 1'b1; m0_readdata = 32'hDEAD;
            tick();
        end
        m0_readdatavalid = 1'b0;
        chk("late_discard", rsp_valid, 1'b0);
        chk("late_busy", busy, 1'b0);
        cmd_valid = 1'b1;
        #1 chk("late_unblocked", cmd_ready, 1'b1);

        // Reset while a read is stalled in the request phase
        cmd_address = 9'h50; m0_waitrequest = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("mid_req_read", m0_read, 1'b1);
        reset_reset = 1'b1;
        tick();
        reset_reset = 1'b0;
        m0_waitrequest = 1'b0;
        chk("mid_rst_read", m0_read, 1'b0);
        chk("mid_rst_addr", m0_address, 9'h0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_err", err_sticky, 1'b0);
        chk("mid_rst_rsp", rsp_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
